// File: rtl/bcd_updown_counter_pkg.sv
// Shared BCD decade constants and the load-value clamp used by every digit.
package bcd_updown_counter_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: load with clamp, up/down step gated by the incoming carry/borrow.
// Registered digit, combinational carry-out so a whole chain resolves in one cycle.
module bcd_digit
    import bcd_updown_counter_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LD,
    input  logic [BCD_W-1:0] LD_VAL,
    input  logic             STEP,
    input  logic             DN,
    input  logic             CI,
    output logic [BCD_W-1:0] Q,
    output logic             CO
);

    assign CO = CI & (DN ? (Q == BCD_ZERO) : (Q == BCD_MAX));

    // Out-of-range states fold back into BCD on the next step.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            Q <= BCD_ZERO;
        end else if (LD) begin
            Q <= bcd_clamp(LD_VAL);
        end else if (STEP && CI) begin
            if (DN) begin
                Q <= (Q == BCD_ZERO || Q > BCD_MAX) ? BCD_MAX : Q - 4'd1;
            end else begin
                Q <= (Q >= BCD_MAX) ? BCD_ZERO : Q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with prescaler, parallel load and wrap/saturate terminal mode.
// All outputs registered; CNT/OVF/ZERO update on the edge of the step or load.
module bcd_updown_counter
    import bcd_updown_counter_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  EN,
    input  logic                  REVERSE,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   LOAD_VAL,
    output logic [4*DIGITS-1:0]   CNT,
    output logic                  OVF,
    output logic                  ZERO
);

    localparam int                  PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [4*DIGITS-1:0] CNT_ONE = (4*DIGITS)'(1);

    logic [PS_W-1:0] ps;
    logic            step;
    logic            terminal;
    logic            advance;
    logic [DIGITS:0] carry;

    assign step     = EN && (ps == PS_LAST);
    assign carry[0] = step;
    assign terminal = carry[DIGITS];
    // Saturate mode freezes every digit when the step would leave the terminal value.
    assign advance  = !((SATURATE != 0) && terminal);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .CLK    (CLK),
            .RESET  (RESET),
            .LD     (LOAD),
            .LD_VAL (LOAD_VAL[BCD_W*i +: BCD_W]),
            .STEP   (advance),
            .DN     (REVERSE),
            .CI     (carry[i]),
            .Q      (CNT[BCD_W*i +: BCD_W]),
            .CO     (carry[i+1])
        );
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ps   <= '0;
            OVF  <= 1'b0;
            ZERO <= 1'b1;
        end else if (LOAD) begin
            ps   <= '0;
            OVF  <= 1'b0;
            ZERO <= (LOAD_VAL == '0);
        end else begin
            OVF <= step && terminal;
            if (EN) begin
                ps <= step ? '0 : ps + 1'b1;
            end
            // Predict ZERO from the current count so it lands with the new CNT.
            if (step) begin
                if (terminal) begin
                    ZERO <= REVERSE ? (SATURATE != 0) : (SATURATE == 0);
                end else begin
                    ZERO <= REVERSE && (CNT == CNT_ONE);
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed checks of reset, up/down wrap and saturate, prescaler, load clamp, plus a 4-digit soak.
module tb_bcd_updown_counter;

    logic        CLK;
    logic        RESET;
    logic        EN;
    logic        REVERSE;
    logic        LOAD;
    logic [15:0] LOAD_VAL;

    logic [11:0] cnt_a, cnt_s, cnt_p;
    logic [15:0] cnt_d;
    logic        ovf_a, ovf_s, ovf_p, ovf_d;
    logic        zero_a, zero_s, zero_p, zero_d;

    int n_checks = 0;
    int n_errors = 0;

    bcd_updown_counter #(.DIGITS(3), .PRESCALE(1), .SATURATE(0)) u_a (
        .CLK(CLK), .RESET(RESET), .EN(EN), .REVERSE(REVERSE), .LOAD(LOAD),
        .LOAD_VAL(LOAD_VAL[11:0]), .CNT(cnt_a), .OVF(ovf_a), .ZERO(zero_a));
    bcd_updown_counter #(.DIGITS(3), .PRESCALE(1), .SATURATE(1)) u_s (
        .CLK(CLK), .RESET(RESET), .EN(EN), .REVERSE(REVERSE), .LOAD(LOAD),
        .LOAD_VAL(LOAD_VAL[11:0]), .CNT(cnt_s), .OVF(ovf_s), .ZERO(zero_s));
    bcd_updown_counter #(.DIGITS(3), .PRESCALE(4), .SATURATE(0)) u_p (
        .CLK(CLK), .RESET(RESET), .EN(EN), .REVERSE(REVERSE), .LOAD(LOAD),
        .LOAD_VAL(LOAD_VAL[11:0]), .CNT(cnt_p), .OVF(ovf_p), .ZERO(zero_p));
    bcd_updown_counter #(.DIGITS(4), .PRESCALE(1), .SATURATE(0)) u_d (
        .CLK(CLK), .RESET(RESET), .EN(EN), .REVERSE(REVERSE), .LOAD(LOAD),
        .LOAD_VAL(LOAD_VAL), .CNT(cnt_d), .OVF(ovf_d), .ZERO(zero_d));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd2dec(input logic [15:0] v);
        int d = 0;
        int p = 1;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] n;
            n = v[4*k +: 4];
            d += ((n > 4'd9) ? 9 : int'(n)) * p;
            p *= 10;
        end
        return d;
    endfunction

    function automatic logic [15:0] dec2bcd(input int d);
        logic [15:0] r;
        int x = d;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    initial begin
        int      m;
        logic    m_ovf;
        RESET = 1'b0; EN = 1'b1; LOAD = 1'b1; REVERSE = 1'b0; LOAD_VAL = 16'h0555;

        // reset dominates LOAD and EN
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_cnt", cnt_a, 12'h000);
            chk("rst_zero", zero_a, 1'b1);
            chk("rst_ovf", ovf_a, 1'b0);
            chk("rst_cnt_d", cnt_d, 16'h0000);
        end

        // count up across a carry, then wrap from 999
        RESET = 1'b1; EN = 1'b0; LOAD = 1'b1; LOAD_VAL = 16'h0098;
        tick();
        chk("ld_098", cnt_a, 12'h098);
        LOAD = 1'b0; EN = 1'b1;
        tick();
        chk("up_099", cnt_a, 12'h099);
        tick();
        chk("up_100", cnt_a, 12'h100);
        chk("up_100_zero", zero_a, 1'b0);
        EN = 1'b0; LOAD = 1'b1; LOAD_VAL = 16'h0999;
        tick();
        LOAD = 1'b0; EN = 1'b1;
        tick();
        chk("wrap_up_cnt", cnt_a, 12'h000);
        chk("wrap_up_ovf", ovf_a, 1'b1);
        chk("wrap_up_zero", zero_a, 1'b1);
        chk("sat_up_cnt", cnt_s, 12'h999);
        chk("sat_up_ovf", ovf_s, 1'b1);
        EN = 1'b0;
        tick();
        chk("ovf_pulse_end", ovf_a, 1'b0);

        // count down, borrow, wrap and saturate at zero
        REVERSE = 1'b1; LOAD = 1'b1; LOAD_VAL = 16'h0100;
        tick();
        LOAD = 1'b0; EN = 1'b1;
        tick();
        chk("dn_099", cnt_a, 12'h099);
        chk("dn_099_zero", zero_a, 1'b0);
        EN = 1'b0; LOAD = 1'b1; LOAD_VAL = 16'h0000;
        tick();
        chk("ld_000_zero", zero_a, 1'b1);
        LOAD = 1'b0; EN = 1'b1;
        tick();
        chk("wrap_dn_cnt", cnt_a, 12'h999);
        chk("wrap_dn_ovf", ovf_a, 1'b1);
        chk("wrap_dn_zero", zero_a, 1'b0);
        chk("sat_dn_cnt", cnt_s, 12'h000);
        chk("sat_dn_ovf", ovf_s, 1'b1);
        tick();
        chk("sat_dn_cnt2", cnt_s, 12'h000);
        chk("sat_dn_ovf2", ovf_s, 1'b1);
        chk("sat_dn_zero2", zero_s, 1'b1);
        chk("dn_998", cnt_a, 12'h998);
        chk("dn_998_ovf", ovf_a, 1'b0);
        EN = 1'b0;
        tick();
        chk("sat_ovf_idle", ovf_s, 1'b0);

        // prescaler of 4: continuous enable, then 50% enable
        REVERSE = 1'b0; LOAD = 1'b1; LOAD_VAL = 16'h0000;
        tick();
        LOAD = 1'b0; EN = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk("ps_cont", cnt_p, 12'(c / 4));
        end
        for (int i = 0; i < 8; i++) begin
            EN = (i % 2 == 0);
            tick();
            if (i == 5) chk("ps_toggle_hold", cnt_p, 12'h002);
            if (i == 7) chk("ps_toggle_step", cnt_p, 12'h003);
        end

        // load clamps nibbles, beats a step and restarts the prescaler
        EN = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        LOAD = 1'b1; LOAD_VAL = 16'h0A5F;
        tick();
        chk("clamp_cnt", cnt_a, 12'h959);
        chk("clamp_ovf", ovf_a, 1'b0);
        chk("clamp_cnt_p", cnt_p, 12'h959);
        chk("clamp_zero", zero_s, 1'b0);
        LOAD = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("ps_restart_hold", cnt_p, 12'h959);
        tick();
        chk("ps_restart_step", cnt_p, 12'h960);

        // reset mid-count restarts the prescaler phase
        tick(); tick();
        RESET = 1'b0;
        tick();
        chk("midrst_cnt", cnt_p, 12'h000);
        chk("midrst_zero", zero_p, 1'b1);
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("midrst_hold", cnt_p, 12'h000);
        tick();
        chk("midrst_step", cnt_p, 12'h001);
        chk("midrst_zero_clr", zero_p, 1'b0);

        // 4-digit soak against a decimal model, with random reversals and loads
        EN = 1'b0; LOAD = 1'b1; LOAD_VAL = 16'h9998; REVERSE = 1'b0;
        tick();
        m = 9998;
        chk("soak_ld", cnt_d, dec2bcd(m));
        for (int i = 0; i < 400; i++) begin
            LOAD     = ($urandom_range(0, 19) == 0);
            LOAD_VAL = 16'($urandom);
            EN       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) REVERSE = ~REVERSE;
            m_ovf = 1'b0;
            if (LOAD) begin
                m = bcd2dec(LOAD_VAL);
            end else if (EN) begin
                if (!REVERSE) begin
                    m_ovf = (m == 9999);
                    m = (m + 1) % 10000;
                end else begin
                    m_ovf = (m == 0);
                    m = (m + 9999) % 10000;
                end
            end
            tick();
            chk("soak_cnt", cnt_d, dec2bcd(m));
            chk("soak_ovf", ovf_d, m_ovf);
            chk("soak_zero", zero_d, (m == 0));
            for (int k = 0; k < 4; k++) begin
                chk("soak_nibble_bcd", (cnt_d[4*k +: 4] <= 4'd9), 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
